// File: rtl/uart_pkg.sv
// Shared encodings and constants for the UART transmit path.
package uart_pkg;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_e;

   localparam logic PAR_EVEN     = 1'b0;
   localparam logic PAR_ODD      = 1'b1;
   localparam int   PRESCALE_MIN = 2;

   // data_xor is the XOR-reduction of the data word.
   function automatic logic parity_bit(input logic data_xor, input logic par_typ);
      return (par_typ == PAR_EVEN) ? data_xor : ~data_xor;
   endfunction

endpackage

// File: rtl/uart_tx_baud_cnt.sv
// Per-bit prescale counter: counts 0..P-1 and pulses bit_done_o on the last cycle of a bit.
module uart_tx_baud_cnt #(
   parameter int PRESCALE_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      srst,
   input  logic                      clear_i,
   input  logic [PRESCALE_WIDTH-1:0] prescale_i,
   output logic                      bit_done_o
);

   logic [PRESCALE_WIDTH-1:0] cnt_q;
   logic [PRESCALE_WIDTH-1:0] cnt_d;
   logic                      at_end;

   assign at_end     = (cnt_q == (prescale_i - PRESCALE_WIDTH'(1)));
   assign bit_done_o = at_end & ~clear_i;

   always_comb begin
      cnt_d = cnt_q + PRESCALE_WIDTH'(1);
      if (clear_i || at_end) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that pops bytes from the TX FIFO read stage and serialises them
// as start / data (LSB first) / optional parity / stop.
module uart_tx_fifo_drain
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 16
) (
   input  logic                      i_uart_tx_clk,
   input  logic                      i_uart_tx_rst,
   input  logic                      i_uart_tx_en,
   input  logic [PRESCALE_WIDTH-1:0] i_uart_tx_prescale,
   input  logic                      i_uart_tx_par_en,
   input  logic                      i_uart_tx_par_typ,
   input  logic                      i_uart_tx_fifo_empty,
   input  logic [DATA_WIDTH-1:0]     i_uart_tx_fifo_rdata,
   output logic                      o_uart_tx_fifo_rinc,
   output logic                      o_uart_tx_serial,
   output logic                      o_uart_tx_busy
);

   localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

   tx_state_e                 state_q, state_d;
   logic [DATA_WIDTH-1:0]     shreg_q, shreg_d;
   logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
   logic                      par_en_q, par_en_d;
   logic                      par_bit_q, par_bit_d;
   logic                      serial_q, serial_d;
   logic                      busy_q, busy_d;

   logic                      rinc;
   logic                      bit_done;
   logic [PRESCALE_WIDTH-1:0] prescale_clamped;

   assign prescale_clamped = (i_uart_tx_prescale < PRESCALE_WIDTH'(PRESCALE_MIN))
                           ? PRESCALE_WIDTH'(PRESCALE_MIN) : i_uart_tx_prescale;

   // Reset gates the pop so no byte is lost while the FSM is being forced idle.
   assign rinc = (state_q == TX_IDLE) & i_uart_tx_en & ~i_uart_tx_fifo_empty & ~i_uart_tx_rst;

   uart_tx_baud_cnt #(
      .PRESCALE_WIDTH(PRESCALE_WIDTH)
   ) u_baud (
      .clk       (i_uart_tx_clk),
      .srst      (i_uart_tx_rst),
      .clear_i   (state_q == TX_IDLE),
      .prescale_i(prescale_q),
      .bit_done_o(bit_done)
   );

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      bit_cnt_d  = bit_cnt_q;
      prescale_d = prescale_q;
      par_en_d   = par_en_q;
      par_bit_d  = par_bit_q;
      serial_d   = serial_q;
      busy_d     = busy_q;

      case (state_q)
         TX_IDLE: begin
            serial_d = 1'b1;
            busy_d   = 1'b0;
            if (rinc) begin
               shreg_d    = i_uart_tx_fifo_rdata;
               prescale_d = prescale_clamped;
               par_en_d   = i_uart_tx_par_en;
               par_bit_d  = parity_bit(^i_uart_tx_fifo_rdata, i_uart_tx_par_typ);
               state_d    = TX_START;
               serial_d   = 1'b0;
               busy_d     = 1'b1;
            end
         end
         TX_START: begin
            if (bit_done) begin
               state_d   = TX_DATA;
               bit_cnt_d = '0;
               serial_d  = shreg_q[0];
            end
         end
         TX_DATA: begin
            if (bit_done) begin
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = '0;
                  if (par_en_q) begin
                     state_d  = TX_PARITY;
                     serial_d = par_bit_q;
                  end else begin
                     state_d  = TX_STOP;
                     serial_d = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                  shreg_d   = shreg_q >> 1;
                  serial_d  = shreg_d[0];
               end
            end
         end
         TX_PARITY: begin
            if (bit_done) begin
               state_d  = TX_STOP;
               serial_d = 1'b1;
            end
         end
         TX_STOP: begin
            if (bit_done) begin
               state_d  = TX_IDLE;
               serial_d = 1'b1;
               busy_d   = 1'b0;
            end
         end
         default: begin
            state_d  = TX_IDLE;
            serial_d = 1'b1;
            busy_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_uart_tx_clk) begin
      if (i_uart_tx_rst) begin
         state_q    <= TX_IDLE;
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         prescale_q <= PRESCALE_WIDTH'(PRESCALE_MIN);
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         serial_q   <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bit_cnt_q  <= bit_cnt_d;
         prescale_q <= prescale_d;
         par_en_q   <= par_en_d;
         par_bit_q  <= par_bit_d;
         serial_q   <= serial_d;
         busy_q     <= busy_d;
      end
   end

   assign o_uart_tx_fifo_rinc = rinc;
   assign o_uart_tx_serial    = serial_q;
   assign o_uart_tx_busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Scoreboard bench: the FIFO model records each popped byte with the config in force at the pop;
// a line monitor decodes every frame and compares it against the expected waveform.
module tb_uart_tx_fifo_drain;

   localparam int DW = 8;
   localparam int PW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic [PW-1:0] prescale;
   logic          par_en;
   logic          par_typ;
   logic          fifo_empty = 1'b1;
   logic [DW-1:0] rdata = '0;
   logic          rinc;
   logic          serial;
   logic          busy;

   always #5 clk = ~clk;

   uart_tx_fifo_drain #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
      .i_uart_tx_clk       (clk),
      .i_uart_tx_rst       (rst),
      .i_uart_tx_en        (en),
      .i_uart_tx_prescale  (prescale),
      .i_uart_tx_par_en    (par_en),
      .i_uart_tx_par_typ   (par_typ),
      .i_uart_tx_fifo_empty(fifo_empty),
      .i_uart_tx_fifo_rdata(rdata),
      .o_uart_tx_fifo_rinc (rinc),
      .o_uart_tx_serial    (serial),
      .o_uart_tx_busy      (busy)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   typedef struct {
      logic [7:0] data;
      bit         pe;
      bit         pt;
      int         p;
   } frame_t;

   frame_t     exp_q[$];
   logic [7:0] fifo_q[$];
   longint     pop_cyc[$];
   longint     cyc = 0;
   int         pops = 0;
   int         pushes = 0;
   int         aborts = 0;
   int         frames_done = 0;
   bit         expect_abort = 1'b0;
   frame_t     popped;

   // FIFO read stage model: registered empty flag, pops on rinc, records expected frame.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rinc === 1'b1) begin
         if (fifo_q.size() == 0) begin
            check("pop_from_empty", 32'd1, 32'd0);
         end else begin
            popped.data = fifo_q.pop_front();
            popped.pe   = par_en;
            popped.pt   = par_typ;
            popped.p    = (prescale < 2) ? 2 : int'(prescale);
            exp_q.push_back(popped);
            pops++;
            pop_cyc.push_back(cyc);
         end
      end
      fifo_empty <= (fifo_q.size() == 0);
      rdata      <= (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
   end

   // Line monitor.
   bit          in_frame = 1'b0;
   bit          stray_seen = 1'b0;
   bit          werr;
   int          k;
   int          nbits;
   frame_t      cur;
   logic [11:0] bits;

   always @(negedge clk) begin
      if (!in_frame && busy === 1'b1) begin
         if (exp_q.size() == 0) begin
            if (!stray_seen) check("unexpected_frame", 32'd1, 32'd0);
            stray_seen = 1'b1;
         end else begin
            cur   = exp_q.pop_front();
            nbits = cur.pe ? 11 : 10;
            bits  = '1;
            bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) bits[1+i] = cur.data[i];
            if (cur.pe) bits[9] = ($countones(cur.data) % 2 == 1) ^ cur.pt;
            in_frame = 1'b1;
            werr = 1'b0;
            k = 0;
         end
      end else if (busy !== 1'b1) begin
         stray_seen = 1'b0;
      end
      if (in_frame) begin
         if (k < nbits * cur.p) begin
            if (busy !== 1'b1) begin
               if (expect_abort) begin
                  aborts++;
                  $display("frame %02h aborted by reset after %0d cycles", cur.data, k);
               end else begin
                  check("frame_len", k, nbits * cur.p);
               end
               in_frame = 1'b0;
            end else begin
               if (serial !== bits[k / cur.p]) werr = 1'b1;
               k++;
            end
         end else begin
            check("idle_gap", {30'd0, serial, busy}, 32'd2);
            check("frame_wave", {31'd0, werr}, 32'd0);
            $display("frame %02h P=%0d par_en=%0d par_typ=%0d cycles=%0d wave=%s",
                     cur.data, cur.p, cur.pe, cur.pt, k, werr ? "wrong" : "ok");
            frames_done++;
            in_frame = 1'b0;
         end
      end
   end

   task automatic push(input logic [7:0] b);
      fifo_q.push_back(b);
      pushes++;
   endtask

   task automatic wait_drain(input int budget, input string name);
      int quiet = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (fifo_q.size() == 0 && exp_q.size() == 0 && !in_frame && busy === 1'b0) quiet++;
         else quiet = 0;
         if (quiet >= 3) return;
      end
      check(name, 32'd0, 32'd1);
   endtask

   task automatic wait_busy(input string name);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (busy === 1'b1) return;
      end
      check(name, 32'd0, 32'd1);
   endtask

   task automatic reset_pulse(input int ncyc);
      expect_abort = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < ncyc; i++) begin
         @(posedge clk);
         #1;
         check("reset_outputs", {29'd0, serial, busy, rinc}, 32'd4);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      expect_abort = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      // Reset held with a non-empty FIFO: outputs idle, no pop.
      rst = 1'b1; en = 1'b1; prescale = 16'd4; par_en = 1'b0; par_typ = 1'b0;
      push(8'hA5);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         check("reset_outputs", {29'd0, serial, busy, rinc}, 32'd4);
      end
      @(negedge clk);
      rst = 1'b0;
      wait_drain(200, "drain_a5");
      check("pops_a5", pops, 1);

      // Parity even then odd on 0x07 at P=2.
      prescale = 16'd2; par_en = 1'b1; par_typ = 1'b0;
      push(8'h07);
      wait_drain(200, "drain_par_even");
      par_typ = 1'b1;
      push(8'h07);
      wait_drain(200, "drain_par_odd");

      // Back-to-back frames at P=4: pops 41 cycles apart.
      prescale = 16'd4; par_en = 1'b0;
      push(8'h11); push(8'h22);
      wait_drain(300, "drain_b2b");
      check("b2b_pop_spacing", 32'(pop_cyc[$] - pop_cyc[$-1]), 32'd41);

      // Reset mid-DATA: frame dropped, next byte sent cleanly.
      push(8'h3C); push(8'h5A);
      wait_busy("busy_3c");
      repeat (12) @(negedge clk);
      p0 = pops;
      reset_pulse(1);
      check("pops_after_reset", pops, p0 + 1);
      wait_drain(300, "drain_after_reset");
      check("aborts", aborts, 1);

      // Prescale change mid-frame, then prescale 0 clamped to 2.
      push(8'h81); push(8'h42);
      wait_busy("busy_81");
      repeat (5) @(negedge clk);
      prescale = 16'd8;
      wait_drain(400, "drain_presc");
      prescale = 16'd0;
      push(8'hC3);
      wait_drain(200, "drain_presc0");

      // Enable dropped mid-frame: current frame finishes, nothing more pops.
      prescale = 16'd3;
      push(8'h01); push(8'h02); push(8'h03);
      wait_busy("busy_en");
      p0 = pops;
      repeat (3) @(negedge clk);
      en = 1'b0;
      repeat (80) @(negedge clk);
      check("en_off_pops", pops, p0);
      check("en_off_busy", {31'd0, busy}, 32'd0);
      en = 1'b1;
      wait_drain(400, "drain_en");

      // Randomized traffic with config churn mid-frame.
      for (int it = 0; it < 30; it++) begin
         int nb;
         nb = $urandom_range(0, 3);
         for (int j = 0; j < nb; j++) push(8'($urandom_range(0, 255)));
         prescale = 16'($urandom_range(0, 6));
         par_en   = 1'($urandom_range(0, 1));
         par_typ  = 1'($urandom_range(0, 1));
         en       = ($urandom_range(0, 4) != 0);
         repeat ($urandom_range(1, 40)) @(negedge clk);
      end
      en = 1'b1;
      wait_drain(6000, "drain_random");

      check("exp_queue_empty", exp_q.size(), 0);
      check("all_popped", pops, pushes);
      check("frames_accounted", frames_done + aborts, pops);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
